// File: rtl/shifter8_seq_right.sv
// Multi-cycle right shifter: captures an operand and shift amount on start,
// shifts one bit per clock (logical or arithmetic), then pulses done.
module shifter8_seq_right #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] d_in,
   input  logic [SHW-1:0]   shamt,
   output logic [WIDTH-1:0] d_out,
   output logic             c_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
   localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

   state_t           state_r;
   logic [WIDTH-1:0] sh_r;
   logic [SHW-1:0]   cnt_r;
   logic             op_r;
   logic             fill_s;
   logic [WIDTH-1:0] shifted_s;

   // One-position right shift of the working register; ASR replicates the sign bit
   always_comb begin
      fill_s    = op_r & sh_r[WIDTH-1];
      shifted_s = {fill_s, sh_r[WIDTH-1:1]};
   end

   // Control FSM with registered result, carry, busy and done
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         sh_r    <= {WIDTH{1'b0}};
         cnt_r   <= CNT_ZERO;
         op_r    <= 1'b0;
         d_out   <= {WIDTH{1'b0}};
         c_out   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  sh_r  <= d_in;
                  cnt_r <= shamt;
                  op_r  <= op;
                  c_out <= 1'b0;
                  busy  <= 1'b1;
                  // A zero shift skips SHIFT and reports the operand unchanged
                  if (shamt == CNT_ZERO) begin
                     d_out   <= d_in;
                     done    <= 1'b1;
                     state_r <= DONE;
                  end else begin
                     state_r <= SHIFT;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            SHIFT: begin
               c_out <= sh_r[0];
               sh_r  <= shifted_s;
               cnt_r <= cnt_r - CNT_ONE;
               busy  <= 1'b1;
               if (cnt_r == CNT_ONE) begin
                  d_out   <= shifted_s;
                  done    <= 1'b1;
                  state_r <= DONE;
               end else begin
                  done    <= 1'b0;
                  state_r <= SHIFT;
               end
            end
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shifter8_seq_right.sv
// Directed self-checking bench for shifter8_seq_right: latency, results,
// carry, busy length, mid-operation reset and back-to-back requests.
module tb_shifter8_seq_right;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic       op;
   logic [7:0] d_in;
   logic [2:0] shamt;
   logic [7:0] d_out;
   logic       c_out;
   logic       busy;
   logic       done;

   int pass_cnt  = 0;
   int check_cnt = 0;

   shifter8_seq_right #(.WIDTH(8), .SHW(3)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .start  (start),
      .op     (op),
      .d_in   (d_in),
      .shamt  (shamt),
      .d_out  (d_out),
      .c_out  (c_out),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, wait for done (bounded), check latency, busy length, result
   task automatic run_op(input string tag, input logic [7:0] d, input logic o,
                         input logic [2:0] s, input logic [7:0] exp_d, input logic exp_c);
      int n;
      int bc;
      d_in = d; op = o; shamt = s; start = 1'b1;
      tick();
      start = 1'b0;
      d_in = ~d;
      n = 0;
      bc = busy ? 1 : 0;
      while (!done && n < 20) begin
         tick();
         n++;
         if (busy) bc++;
      end
      check({tag, "_latency"}, n, s);
      check({tag, "_busy_cycles"}, bc, s + 1);
      check({tag, "_d_out"}, d_out, exp_d);
      check({tag, "_c_out"}, c_out, exp_c);
      tick();
      check({tag, "_done_pulse"}, done, 1'b0);
      check({tag, "_busy_idle"}, busy, 1'b0);
      check({tag, "_d_out_hold"}, d_out, exp_d);
   endtask

   initial begin
      int n;
      int dcnt;
      int first_at;
      int second_at;
      logic [7:0] first_d;
      logic [7:0] second_d;
      logic       second_c;

      reset_n = 1'b0; start = 1'b0; op = 1'b0; d_in = 8'h00; shamt = 3'd0;
      #12;
      check("rst_d_out", d_out, 8'h00);
      check("rst_c_out", c_out, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      run_op("lsr1", 8'b10101101, 1'b0, 3'd1, 8'b01010110, 1'b1);
      run_op("lsr3", 8'b10101101, 1'b0, 3'd3, 8'b00010101, 1'b1);
      run_op("asr3", 8'b10101101, 1'b1, 3'd3, 8'b11110101, 1'b1);
      run_op("asr7", 8'b10101101, 1'b1, 3'd7, 8'b11111111, 1'b0);
      run_op("lsr0", 8'b10101101, 1'b0, 3'd0, 8'b10101101, 1'b0);
      run_op("asr0", 8'b10101101, 1'b1, 3'd0, 8'b10101101, 1'b0);

      // Operand change and start toggling while busy must not disturb the result
      d_in = 8'b10101101; op = 1'b0; shamt = 3'd3; start = 1'b1;
      tick();
      d_in = 8'h00; shamt = 3'd7; op = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      check("chg_done", done, 1'b1);
      check("chg_d_out", d_out, 8'b00010101);
      check("chg_c_out", c_out, 1'b1);
      start = 1'b0;
      tick();
      check("chg_no_extra_done1", done, 1'b0);
      tick();
      check("chg_no_extra_done2", done, 1'b0);
      check("chg_idle", busy, 1'b0);

      // Reset in the third SHIFT cycle aborts with no done
      d_in = 8'b10101101; op = 1'b0; shamt = 3'd5; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("abort_busy_before", busy, 1'b1);
      reset_n = 1'b0;
      #1;
      check("abort_d_out", d_out, 8'h00);
      check("abort_c_out", c_out, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      tick();
      reset_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done) dcnt++;
      end
      check("abort_no_done", dcnt, 0);
      run_op("post_rst", 8'h80, 1'b0, 3'd2, 8'h20, 1'b0);

      // Back-to-back requests with start held high
      d_in = 8'hF0; op = 1'b0; shamt = 3'd2; start = 1'b1;
      tick();
      d_in = 8'h90; op = 1'b1; shamt = 3'd4;
      dcnt = 0; first_at = -1; second_at = -1;
      first_d = 8'h00; second_d = 8'h00; second_c = 1'b1;
      for (n = 1; n <= 14; n++) begin
         tick();
         if (n == 4) start = 1'b0;
         if (done) begin
            dcnt++;
            if (dcnt == 1) begin
               first_at = n; first_d = d_out;
            end else begin
               second_at = n; second_d = d_out; second_c = c_out;
            end
         end
      end
      check("b2b_done_count", dcnt, 2);
      check("b2b_first_at", first_at, 2);
      check("b2b_first_d", first_d, 8'h3C);
      check("b2b_second_at", second_at, 8);
      check("b2b_second_d", second_d, 8'hF9);
      check("b2b_second_c", second_c, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/shifter8_seq_right.md
Name: shifter8_seq_right

Overview:
- Multi-cycle right shifter for the 8-bit shifter family. It is the right-direction counterpart to the combinational left shifter.
- Captures an operand and a shift amount on a start request. Shifts one bit position per clock, logical or arithmetic.
- Reports the result, the last bit shifted out, and a one-cycle done pulse.
- Used by the datapath wherever a right shift is allowed a variable number of cycles.

Parameters:
- WIDTH, 8, operand/result width in bits.
- SHW, 3, shift-amount width; maximum shift is 2^SHW-1 = 7.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = logical shift right (LSR, zero fill), 1 = arithmetic shift right (ASR, sign fill)
- d_in  input  WIDTH  operand, captured with start
- shamt  input  SHW  shift amount, captured with start
- d_out  output  WIDTH  result register
- c_out  output  1  last bit shifted out; 0 when shamt=0
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse, result valid

Behaviour:
- Reset is asynchronous, active-low and takes effect immediately:
  - state=IDLE, internal shift register=0, count=0, latched op=0.
  - d_out=0, c_out=0, busy=0, done=0.
  - Reset during SHIFT or DONE aborts the operation; no done pulse is produced.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - busy=0, done=0; d_out and c_out hold the previous result.
  - On a clock edge with start=1: latch d_in into the shift register, latch shamt into the counter, latch op, and clear c_out.
  - If shamt=0: d_out<=d_in, c_out<=0, go to DONE.
  - Otherwise go to SHIFT.
- SHIFT: on each edge:
  - c_out<=reg[0].
  - reg<={fill, reg[WIDTH-1:1]}, where fill=0 for LSR and fill=reg[WIDTH-1] for ASR (latched op).
  - count<=count-1.
  - On the edge where count==1: d_out<=shifted value, go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE unconditionally.
- Latency: counting the start-sampling edge as edge 0, done is high in the cycle following edge max(shamt,0). For shamt=0, done is high in the cycle right after edge 0; for shamt=7, after edge 7.
- start asserted in SHIFT or DONE is ignored, not queued. A new request is accepted in the first IDLE cycle.
- d_in, shamt and op may change freely after capture without affecting the operation in progress.
- A held start re-triggers a new operation every time the block re-enters IDLE.
- d_out and c_out remain stable from done until the next operation's result.

Test Plan:
- d_in=8'b10101101, op=0, shamt=1, start 1 cycle -> done after edge 1, d_out=8'b01010110, c_out=1.
- Same d_in, op=0, shamt=3 -> done after edge 3, d_out=8'b00010101, c_out=1; busy high for 4 cycles (3 SHIFT + 1 DONE).
- Same d_in, op=1, shamt=3 -> d_out=8'b11110101, c_out=1. With op=1, shamt=7 -> d_out=8'b11111111, c_out=0, done after edge 7.
- shamt=0, op either value -> done after edge 0, d_out=8'b10101101, c_out=0. Changing d_in to 8'h00 and toggling start during busy -> result unchanged, no extra done.
- Start LSR shamt=5, assert reset_n=0 during the third SHIFT cycle -> d_out=0, c_out=0, busy=0 immediately, no done. After release, LSR shamt=2 on 8'h80 -> d_out=8'h20, c_out=0.
- Two back-to-back requests with start held high: LSR shamt=2 on 8'hF0 (-> 8'h3C), then ASR shamt=4 on 8'h90 (-> 8'hF9, c_out=0) -> exactly one done per operation, never on consecutive cycles.
